// File: rtl/lmac_crc_pkg.sv
// Shared definitions for the MAC CRC-32 engines: FSM states, CRC constants,
// and a single-bit step of the reflected IEEE 802.3 generator.
package lmac_crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    TAIL,
    DONE
  } fcs_state_e;

  localparam logic [31:0] CRC_INIT_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE_DEF  = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_REF = 32'hEDB8_8320;
  localparam int unsigned BCNT_W       = 3;

  // LSB-first shift of one data bit through the reflected polynomial.
  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    return {1'b0, c[31:1]} ^ (fb ? CRC_POLY_REF : '0);
  endfunction

endpackage

// File: rtl/crc32_d64.sv
// Combinational CRC-32 matrix over 64 data bits from a zero state;
// bit 0 is the first bit on the wire.
module crc32_d64
  import lmac_crc_pkg::*;
(
  input  logic [63:0] i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    o_crc = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      o_crc = crc32_step(o_crc, i_data[i]);
    end
  end

endmodule

// File: rtl/crc32_d8.sv
// Combinational CRC-32 matrix over one byte from a zero state, same bit
// order and generator as crc32_d64.
module crc32_d8
  import lmac_crc_pkg::*;
(
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    o_crc = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      o_crc = crc32_step(o_crc, i_data[i]);
    end
  end

endmodule

// File: rtl/eth_fcs_d64.sv
// Ethernet FCS engine for the 64-bit datapath: full beats fold in one cycle,
// a short final beat drains one byte per cycle through the byte matrix.
module eth_fcs_d64
  import lmac_crc_pkg::*;
#(
  parameter logic [31:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [31:0] RESIDUE  = RESIDUE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [BCNT_W-1:0] in_bcnt,
  output logic              fcs_valid,
  output logic [31:0]       fcs,
  output logic              fcs_ok,
  output logic              sop_err
);

  fcs_state_e        r_state, w_state_nxt;
  logic [31:0]       r_crc, w_crc_nxt;
  logic [63:0]       r_tail, w_tail_nxt;
  logic [BCNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]       r_fcs;
  logic              r_fcs_ok;
  logic              r_sop_err;

  logic              w_accept;
  logic              w_err_nxt;
  logic              w_done;
  logic [31:0]       w_final;
  logic [31:0]       w_src;
  logic [63:0]       w_word_in;
  logic [31:0]       w_word_crc;
  logic [7:0]        w_byte_in;
  logic [31:0]       w_byte_raw;
  logic [31:0]       w_byte_crc;

  assign in_ready  = (r_state != TAIL);
  assign w_accept  = in_valid & in_ready;
  assign w_src     = in_sop ? CRC_INIT : r_crc;
  assign w_word_in = in_data ^ {32'b0, w_src};
  assign w_byte_in = r_tail[7:0] ^ r_crc[7:0];
  assign w_byte_crc = w_byte_raw ^ {8'b0, r_crc[31:8]};

  crc32_d64 u_crc_d64 (
    .i_data (w_word_in),
    .o_crc  (w_word_crc)
  );

  crc32_d8 u_crc_d8 (
    .i_data (w_byte_in),
    .o_crc  (w_byte_raw)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_tail_nxt  = r_tail;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_final     = r_crc;
    w_err_nxt   = 1'b0;

    if (r_state == TAIL) begin
      w_crc_nxt  = w_byte_crc;
      w_tail_nxt = r_tail >> 8;
      w_cnt_nxt  = r_cnt - 1'b1;
      if (r_cnt == BCNT_W'(1)) begin
        w_state_nxt = DONE;
        w_done      = 1'b1;
        w_final     = w_byte_crc;
      end
    end else begin
      // DONE behaves as IDLE so frames can follow with no bubble.
      w_state_nxt = (r_state == BODY) ? BODY : IDLE;
      w_err_nxt   = w_accept & ((r_state == BODY) ? in_sop : ~in_sop);
      if (w_accept && (in_sop || r_state == BODY)) begin
        if (!in_eop) begin
          w_crc_nxt   = w_word_crc;
          w_state_nxt = BODY;
        end else if (in_bcnt == '0) begin
          w_crc_nxt   = w_word_crc;
          w_state_nxt = DONE;
          w_done      = 1'b1;
          w_final     = w_word_crc;
        end else begin
          w_crc_nxt   = w_src;
          w_tail_nxt  = in_data;
          w_cnt_nxt   = in_bcnt;
          w_state_nxt = TAIL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_crc     <= CRC_INIT;
      r_tail    <= '0;
      r_cnt     <= '0;
      r_fcs     <= '0;
      r_fcs_ok  <= 1'b0;
      r_sop_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_crc     <= w_crc_nxt;
      r_tail    <= w_tail_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sop_err <= w_err_nxt;
      if (w_done) begin
        r_fcs    <= ~w_final;
        r_fcs_ok <= (w_final == RESIDUE);
      end
    end
  end

  assign fcs_valid = (r_state == DONE);
  assign fcs       = r_fcs;
  assign fcs_ok    = r_fcs_ok;
  assign sop_err   = r_sop_err;

endmodule

// File: tb/tb_eth_fcs_d64.sv
// Directed bench for eth_fcs_d64 using known CRC-32 check values.
module tb_eth_fcs_d64;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic [2:0]  in_bcnt;
  logic        fcs_valid;
  logic [31:0] fcs;
  logic        fcs_ok;
  logic        sop_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  eth_fcs_d64 #(
    .CRC_INIT (32'hFFFF_FFFF),
    .RESIDUE  (32'hDEBB_20E3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_bcnt   (in_bcnt),
    .fcs_valid (fcs_valid),
    .fcs       (fcs),
    .fcs_ok    (fcs_ok),
    .sop_err   (sop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] d0;
    logic [2:0]  bc0;
    logic        two;
    logic [63:0] d1;
    logic [2:0]  bc1;
    logic        chk_fcs;
    logic [31:0] exp_fcs;
    logic        exp_ok;
    int unsigned exp_lat;
    int unsigned exp_stall;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until a clock edge accepts it.
  task automatic send(input logic [63:0] d, input logic s, input logic e, input logic [2:0] b);
    logic rdy;
    logic ok;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_bcnt  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    if (!ok) chk("accept_timeout", 64'(ok), 64'(1'b1));
  endtask

  // Called #1 after the edge that accepted the EOP beat.
  task automatic wait_result(input string name, input logic chk_fcs, input logic [31:0] exp_fcs,
                             input logic exp_ok, input int unsigned exp_lat,
                             input int unsigned exp_stall);
    int unsigned lat;
    int unsigned stall;
    logic seen;
    lat = 1;
    stall = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fcs_valid) begin
        seen = 1'b1;
        break;
      end
      if (!in_ready) stall++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_seen"}, 64'(seen), 64'(1'b1));
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_stall"}, 64'(stall), 64'(exp_stall));
    chk({name, "_ok"}, 64'(fcs_ok), 64'(exp_ok));
    if (chk_fcs) chk({name, "_fcs"}, 64'(fcs), 64'(exp_fcs));
    @(posedge clk);
    #1;
    chk({name, "_pulse"}, 64'(fcs_valid), 64'(1'b0));
    chk({name, "_hold_ok"}, 64'(fcs_ok), 64'(exp_ok));
    if (chk_fcs) chk({name, "_hold_fcs"}, 64'(fcs), 64'(exp_fcs));
  endtask

  task automatic run_frame(input vec_t v);
    if (v.two) begin
      send(v.d0, 1'b1, 1'b0, 3'd0);
      send(v.d1, 1'b0, 1'b1, v.bc1);
    end else begin
      send(v.d0, 1'b1, 1'b1, v.bc0);
    end
    wait_result(v.name, v.chk_fcs, v.exp_fcs, v.exp_ok, v.exp_lat, v.exp_stall);
  endtask

  initial begin
    // name, d0, bc0, two, d1, bc1, chk_fcs, exp_fcs, exp_ok, lat, stall
    vecs[0] = '{"chk9", 64'h3837363534333231, 3'd0, 1'b1, 64'h39, 3'd1,
                1'b1, 32'hCBF43926, 1'b0, 2, 1};
    vecs[1] = '{"rx_good", 64'h3837363534333231, 3'd0, 1'b1, 64'hCBF4392639, 3'd5,
                1'b1, 32'h2144DF1C, 1'b1, 6, 5};
    vecs[2] = '{"rx_bad", 64'h3837363534333230, 3'd0, 1'b1, 64'hCBF4392639, 3'd5,
                1'b0, 32'h0, 1'b0, 6, 5};
    vecs[3] = '{"one_word", 64'h3837363534333231, 3'd0, 1'b0, 64'h0, 3'd0,
                1'b1, 32'h9AE0DAAF, 1'b0, 1, 0};
    vecs[4] = '{"rx_word", 64'h3837363534333231, 3'd0, 1'b1, 64'h9AE0DAAF, 3'd4,
                1'b1, 32'h2144DF1C, 1'b1, 5, 4};
    vecs[5] = '{"abc", 64'h636261, 3'd3, 1'b0, 64'h0, 3'd0,
                1'b1, 32'h352441C2, 1'b0, 4, 3};
    vecs[6] = '{"a", 64'h61, 3'd1, 1'b0, 64'h0, 3'd0,
                1'b1, 32'hE8B7BE43, 1'b0, 2, 1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_bcnt  = '0;
    #12;
    chk("rst_ready", 64'(in_ready), 64'(1'b1));
    chk("rst_valid", 64'(fcs_valid), 64'(1'b0));
    chk("rst_fcs", 64'(fcs), 64'(32'h0));
    chk("rst_ok", 64'(fcs_ok), 64'(1'b0));
    chk("rst_err", 64'(sop_err), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_frame(vecs[i]);

    // Back-to-back single-beat frames: one result per cycle, no stalls.
    in_data  = 64'h3837363534333231;
    in_sop   = 1'b1;
    in_eop   = 1'b1;
    in_bcnt  = 3'd0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("b2b_valid", 64'(fcs_valid), 64'(1'b1));
      chk("b2b_fcs", 64'(fcs), 64'(32'h9AE0DAAF));
      chk("b2b_ready", 64'(in_ready), 64'(1'b1));
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_end", 64'(fcs_valid), 64'(1'b0));

    // Beat without SOP while idle.
    send(64'h1122334455667788, 1'b0, 1'b0, 3'd0);
    chk("nosop_err", 64'(sop_err), 64'(1'b1));
    chk("nosop_valid", 64'(fcs_valid), 64'(1'b0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("nosop_quiet_err", 64'(sop_err), 64'(1'b0));
      chk("nosop_quiet_valid", 64'(fcs_valid), 64'(1'b0));
    end

    // SOP in mid-frame aborts the old frame and restarts from the preset.
    send(64'hDEADBEEF01234567, 1'b1, 1'b0, 3'd0);
    chk("mid_noerr", 64'(sop_err), 64'(1'b0));
    send(64'h3837363534333231, 1'b1, 1'b0, 3'd0);
    chk("mid_err", 64'(sop_err), 64'(1'b1));
    chk("mid_valid", 64'(fcs_valid), 64'(1'b0));
    send(64'h39, 1'b0, 1'b1, 3'd1);
    chk("mid_err_clr", 64'(sop_err), 64'(1'b0));
    wait_result("mid_new", 1'b1, 32'hCBF43926, 1'b0, 2, 1);

    // Reset during the third cycle of a 7-byte tail.
    run_frame(vecs[4]);
    send(64'h0102030405060708, 1'b1, 1'b0, 3'd0);
    send(64'hA1A2A3A4A5A6A7A8, 1'b0, 1'b1, 3'd7);
    chk("tail_ready_low", 64'(in_ready), 64'(1'b0));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("tail3_ready_low", 64'(in_ready), 64'(1'b0));
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 64'(in_ready), 64'(1'b1));
    chk("mrst_valid", 64'(fcs_valid), 64'(1'b0));
    chk("mrst_fcs", 64'(fcs), 64'(32'h0));
    chk("mrst_ok", 64'(fcs_ok), 64'(1'b0));
    chk("mrst_err", 64'(sop_err), 64'(1'b0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("mrst_no_result", 64'(fcs_valid), 64'(1'b0));
      @(posedge clk);
      #1;
    end
    run_frame(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
